// File: rtl/sprite_ram_arbiter.sv
`timescale 1ns/1ps
// sprite_ram_arbiter
// Shares the single port of the sprite-sheet frame RAM between three users:
//   - pixel path (absolute priority, one read per cycle during active video)
//   - auxiliary read port (HUD / overlay lookups)
//   - sprite-sheet loader write port
// The auxiliary and loader ports split the cycles the pixel path leaves free
// using round-robin. Read data comes back one cycle later, tagged to the
// requester that issued the read.
//
// Build option: define SPRITE_ARB_WRITE_EN to enable the loader write port.
// If it is not defined, the RAM is read-only. wr_gnt, ram_we and wr_starve
// stay at 0, and wr_req is ignored.
module sprite_ram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 4,
  parameter int MAX_WAIT = 1023
) (
  input  logic              Clk,
  input  logic              Reset_n,
  // pixel path
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  // auxiliary read port
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_data,
  output logic              aux_rvalid,
  // loader write port
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  // frame RAM port
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  // status
  output logic              aux_starve,
  output logic              wr_starve,
  output logic [15:0]       pix_conflicts
);

  localparam int              CNT_W    = 10;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  // Owner of the RAM port in the current cycle
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_PIX  = 2'd1,
    OWN_AUX  = 2'd2,
    OWN_WR   = 2'd3
  } owner_e;

  // Which requester the read data arriving next cycle belongs to
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_PIX  = 2'd1,
    TAG_AUX  = 2'd2
  } tag_e;

  owner_e            w_owner;
  logic              w_wr_req;
  logic              r_last_sec;      // 0 = AUX granted last, 1 = WR granted last
  logic [ADDR_W-1:0] r_ram_addr;
  tag_e              r_tag;
  logic [DATA_W-1:0] r_pix_data;
  logic [DATA_W-1:0] r_aux_data;
  logic [CNT_W-1:0]  r_aux_wait;
  logic [CNT_W-1:0]  r_wr_wait;
  logic [CNT_W-1:0]  w_aux_wait_nxt;
  logic [CNT_W-1:0]  w_wr_wait_nxt;
  logic              r_aux_starve;
  logic              r_wr_starve;
  logic [15:0]       r_pix_conflicts;

`ifdef SPRITE_ARB_WRITE_EN
  assign w_wr_req = wr_req;
`else
  // The loader port is compiled out. Its request never reaches the arbiter,
  // so the WR owner, write enable and wr_starve can never become active.
  logic w_unused_wr_req;
  assign w_unused_wr_req = wr_req;
  assign w_wr_req        = 1'b0;
`endif

  // Next wait count: count up while the port is refused, clear otherwise
  function automatic logic [CNT_W-1:0] next_wait(
    input logic             req,
    input logic             gnt,
    input logic [CNT_W-1:0] cnt
  );
    if (req && !gnt) begin
      return (cnt >= WAIT_MAX) ? WAIT_MAX : cnt + 1'b1;
    end
    return '0;
  endfunction

  // Pick this cycle's owner: pixel first, then round-robin among secondaries
  always_comb begin
    // NOTE: a default assigned first on every path keeps always_comb free of
    // inferred latches when a branch does not mention a signal.
    w_owner = OWN_IDLE;
    if (!Reset_n) begin
      w_owner = OWN_IDLE;
    end else if (pix_req) begin
      w_owner = OWN_PIX;
    end else if (aux_req && w_wr_req) begin
      w_owner = r_last_sec ? OWN_AUX : OWN_WR;
    end else if (aux_req) begin
      w_owner = OWN_AUX;
    end else if (w_wr_req) begin
      w_owner = OWN_WR;
    end
  end

  // Drive the RAM port and grants from the selected owner
  always_comb begin
    ram_addr = r_ram_addr;
    ram_we   = 1'b0;
    aux_gnt  = 1'b0;
    wr_gnt   = 1'b0;
    case (w_owner)
      OWN_PIX: ram_addr = pix_addr;
      OWN_AUX: begin
        ram_addr = aux_addr;
        aux_gnt  = 1'b1;
      end
      OWN_WR: begin
        ram_addr = wr_addr;
        ram_we   = 1'b1;
        wr_gnt   = 1'b1;
      end
      default: ;
    endcase
  end

  // Write data only matters while ram_we is high, so it follows the loader
  assign ram_wdata = wr_data;

  // Remember the last driven address so an idle cycle keeps the port steady
  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous and active-low. It is sampled only at the
    // clock edge, so it never appears in the sensitivity list.
    if (!Reset_n) begin
      r_ram_addr <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples pre-edge values no matter the statement order.
      r_ram_addr <= ram_addr;
    end
  end

  // Round-robin pointer follows the last secondary grant
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_last_sec <= 1'b1;
    end else if (w_owner == OWN_AUX) begin
      r_last_sec <= 1'b0;
    end else if (w_owner == OWN_WR) begin
      r_last_sec <= 1'b1;
    end
  end

  // Tag each cycle with the requester whose read data returns next cycle
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_tag <= TAG_NONE;
    end else begin
      case (w_owner)
        OWN_PIX: r_tag <= TAG_PIX;
        OWN_AUX: r_tag <= TAG_AUX;
        default: r_tag <= TAG_NONE;
      endcase
    end
  end

  // Valids are suppressed during reset, so a read already in flight is dropped
  assign pix_valid  = Reset_n && (r_tag == TAG_PIX);
  assign aux_rvalid = Reset_n && (r_tag == TAG_AUX);

  // While valid, data passes straight from the RAM. Otherwise it holds the last value.
  assign pix_data = pix_valid  ? ram_rdata : r_pix_data;
  assign aux_data = aux_rvalid ? ram_rdata : r_aux_data;

  // Capture returned read data so each output holds it between valids
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_pix_data <= '0;
      r_aux_data <= '0;
    end else begin
      if (pix_valid)  r_pix_data <= ram_rdata;
      if (aux_rvalid) r_aux_data <= ram_rdata;
    end
  end

  assign w_aux_wait_nxt = next_wait(aux_req,  aux_gnt, r_aux_wait);
  assign w_wr_wait_nxt  = next_wait(w_wr_req, wr_gnt,  r_wr_wait);

  // Wait counters and sticky starvation flags for the secondary ports
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_aux_wait   <= '0;
      r_wr_wait    <= '0;
      r_aux_starve <= 1'b0;
      r_wr_starve  <= 1'b0;
    end else begin
      r_aux_wait <= w_aux_wait_nxt;
      r_wr_wait  <= w_wr_wait_nxt;
      if (aux_req && !aux_gnt && (w_aux_wait_nxt == WAIT_MAX)) begin
        r_aux_starve <= 1'b1;
      end
      if (w_wr_req && !wr_gnt && (w_wr_wait_nxt == WAIT_MAX)) begin
        r_wr_starve <= 1'b1;
      end
    end
  end

  // Count cycles in which the pixel path blocked a pending secondary request
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_pix_conflicts <= '0;
    end else if (pix_req && (aux_req || w_wr_req) && (r_pix_conflicts != 16'hFFFF)) begin
      r_pix_conflicts <= r_pix_conflicts + 16'd1;
    end
  end

  assign aux_starve    = r_aux_starve;
  assign wr_starve     = r_wr_starve;
  assign pix_conflicts = r_pix_conflicts;

endmodule

// File: doc/sprite_ram_arbiter.md
# sprite_ram_arbiter

Owns the single port of the sprite-sheet RAM (200×200 palette-ID frame RAM, 4-bit entries, synchronous read, one cycle latency). It shares that port between three requesters. The pixel path from the colour mapper has absolute priority. An auxiliary read port (HUD/overlay lookups) and a sprite-sheet loader write port share the leftover cycles round-robin. The block sits between the colour mapper/loader and the frame RAM instance, and returns read data tagged to the requester that issued it.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 4, palette-ID width
- MAX_WAIT, 1023, wait-cycle threshold for the starvation flag; 10-bit counter

Ports:
- Clk  in  1  system clock; all state updates on posedge
- Reset_n  in  1  reset; synchronous, active-low
- pix_req  in  1  pixel path read request, one per cycle during active video
- pix_addr  in  ADDR_W  pixel read address
- pix_data  out  DATA_W  read data for the pixel path
- pix_valid  out  1  pix_data valid; one cycle after the pix_req cycle
- aux_req  in  1  auxiliary read request; held with aux_addr stable until aux_gnt
- aux_addr  in  ADDR_W  auxiliary read address
- aux_gnt  out  1  combinational grant; request consumed this cycle
- aux_data  out  DATA_W  auxiliary read data
- aux_rvalid  out  1  aux_data valid; one cycle after aux_gnt
- wr_req  in  1  loader write request; held with wr_addr and wr_data stable until wr_gnt
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  combinational grant; write performed this cycle
- ram_addr  out  ADDR_W  to frame RAM read/write address
- ram_we  out  1  to frame RAM write enable
- ram_wdata  out  DATA_W  to frame RAM write data
- ram_rdata  in  DATA_W  from frame RAM; valid one cycle after the address
- aux_starve, wr_starve  out  1  sticky starvation flags per secondary port
- pix_conflicts  out  16  saturating count of cycles where pix_req blocked a pending secondary request

## Operation
- Each cycle the block selects exactly one owner: PIX if pix_req=1, otherwise a round-robin pick among pending aux_req and wr_req, otherwise IDLE.
- PIX: ram_addr=pix_addr, ram_we=0. aux_gnt and wr_gnt are 0.
- AUX: ram_addr=aux_addr, ram_we=0, aux_gnt=1.
- WR: ram_addr=wr_addr, ram_we=1, ram_wdata=wr_data, wr_gnt=1.
- IDLE: ram_addr holds its previous registered value, ram_we=0.
- Round-robin pointer (last_sec: 0=AUX, 1=WR):
  - If both secondary ports request, grant the one not named by last_sec.
  - After any secondary grant, last_sec takes the granted port.
  - A single requester is granted regardless of the pointer.
- Read tag pipeline: a 2-bit registered tag (NONE/PIX/AUX) records the owner of each read cycle. The next cycle, ram_rdata is routed to pix_data or aux_data and the matching valid is pulsed. WR cycles record NONE.
- pix_data and aux_data hold their last value when not valid.
- Wait counters, one per secondary port (10-bit):
  - Increments each cycle the port requests without a grant.
  - Clears on grant, or when the request drops.
  - Saturates at MAX_WAIT.
  - On reaching MAX_WAIT the port's *_starve flag sets. It stays set until reset.
- pix_conflicts increments when pix_req=1 and (aux_req or wr_req)=1. Saturates at 16'hFFFF.
- Read and write of the same address in consecutive cycles: the read in cycle N+1 returns the data written in cycle N. No forwarding is needed; the RAM port is single and sequential.

## Timing
- Grants and RAM drive are combinational from the requests plus the registered pointer. Read data is returned with 1-cycle latency.
- Reset (Reset_n=0 at posedge):
  - pix_valid, aux_rvalid, *_starve = 0.
  - pix_data, aux_data = 0; pix_conflicts = 0; counters = 0; last_sec = 1 (AUX wins first tie); tag = NONE.
  - While Reset_n=0, aux_gnt, wr_gnt and ram_we are forced to 0.
- Reset mid-operation: in-flight tagged reads are discarded, and no valid pulses on the cycle after reset.
- Sustained pix_req=1 starves both secondary ports indefinitely, by design; only the flags report it.
- Back-to-back: a secondary port holding its request can be granted every non-PIX cycle. With both pending, grants alternate AUX/WR.

## Configuration
- SPRITE_ARB_WRITE_EN defined: the WR port behaves as above (run-time sprite-sheet loading).
- Not defined:
  - wr_gnt is tied to 0, ram_we to 0, and wr_starve to 0.
  - wr_req is ignored, and round-robin reduces to AUX-only.
  - RAM is read-only, initialised from its image file.

## Test plan
- Reset: hold Reset_n=0 for 3 cycles with all requests high -> gnts=0, ram_we=0, valids=0, pix_conflicts=0. The first cycle after release has no valid pulse.
- Pixel priority: pix_req=1 at addr 16'h0010 with aux_req=1 -> aux_gnt=0, ram_addr=16'h0010, pix_valid=1 next cycle with RAM data, pix_conflicts=1.
- Round-robin: pix_req=0, aux_req=wr_req=1 for 4 cycles -> grants AUX, WR, AUX, WR; aux_rvalid pulses the cycle after each AUX grant.
- Write-then-read: WR addr 16'd1234 data 4'hB, then AUX read of 16'd1234 -> aux_data=4'hB, aux_rvalid=1.
- Starvation: MAX_WAIT=8, pix_req=1 and aux_req=1 for 10 cycles -> aux_starve=1 from the 9th cycle, stays 1 after pix_req drops.
- Macro off: wr_req=1 with pix_req=0, aux_req=0 -> wr_gnt=0, ram_we=0 indefinitely.
